// File: rtl/apb_rr_pkg.sv
// Shared types and defaults for the round-robin APB master: FSM encoding,
// default bus widths and the grant-index width helper.
package apb_rr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_SETUP  = 3'b010,
        ST_ACCESS = 3'b100
    } state_t;

    localparam int DEF_ADDR_W      = 9;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 16;

    // Index width for a requester count; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_rr_master_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// ptr+1 with wrap; the caller owns and updates the pointer.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    int            c;
    logic [ID_W-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        c    = 0;
        cand = '0;
        for (int k = 1; k <= N; k++) begin
            c = int'(ptr) + k;
            if (c >= N) c = c - N;
            cand = ID_W'(c);
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master sharing one slave port between NUM_REQ requesters.
// Define APB_TIMEOUT_EN to add the ACCESS-phase watchdog (rsp_err on expiry).
module apb_rr_master
    import apb_rr_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                        pclk,
    input  logic                        preset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic [id_width(NUM_REQ)-1:0] gnt_id,
    output logic                        busy,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [ADDR_W-1:0]           paddr,
    output logic [DATA_W-1:0]           pwdata,
    output logic                        transfer,
    input  logic [DATA_W-1:0]           prdata,
    input  logic                        pready
);

    localparam int ID_W = id_width(NUM_REQ);

    state_t            state_reg;
    logic [ID_W-1:0]   ptr_reg;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;
    logic              timeout_hit;
    logic              xfer_done;
    logic              launch;

    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_reg),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] to_cnt_reg;

    // Fires on the last permitted wait cycle; a same-edge pready takes priority.
    assign timeout_hit = (state_reg == ST_ACCESS) && !pready &&
                         (to_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            to_cnt_reg <= '0;
        end else if (state_reg == ST_SETUP) begin
            to_cnt_reg <= '0;
        end else if (state_reg == ST_ACCESS && !pready) begin
            to_cnt_reg <= to_cnt_reg + CNT_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout_hit        = 1'b0;
`endif

    assign xfer_done = (state_reg == ST_ACCESS) && (pready || timeout_hit);
    // A new command is accepted from IDLE or on the completing edge (back-to-back).
    assign launch    = pick_any && ((state_reg == ST_IDLE) || xfer_done);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= ID_W'(NUM_REQ - 1);
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            gnt_id    <= '0;
            busy      <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            transfer  <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            unique case (state_reg)
                ST_IDLE: ;
                ST_SETUP: begin
                    penable   <= 1'b1;
                    state_reg <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (xfer_done) begin
                        rsp_valid <= NUM_REQ'(1) << gnt_id;
                        rsp_rdata <= (pwrite || !pready) ? '0 : prdata;
                        rsp_err   <= timeout_hit;
                        penable   <= 1'b0;
                        psel      <= 1'b0;
                        transfer  <= 1'b0;
                        busy      <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
            if (launch) begin
                pwrite    <= req_write[pick_idx];
                paddr     <= addr_arr[pick_idx];
                pwdata    <= wdata_arr[pick_idx];
                req_ready <= pick_gnt;
                gnt_id    <= pick_idx;
                ptr_reg   <= pick_idx;
                psel      <= 1'b1;
                penable   <= 1'b0;
                transfer  <= 1'b1;
                busy      <= 1'b1;
                state_reg <= ST_SETUP;
            end
        end
    end

endmodule
